// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_ctrl_pkg;

   localparam int unsigned DIV_W = 32;
   localparam logic [DIV_W-1:0] MIN_BAUD_DIV = DIV_W'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // Divisors below the minimum cannot place a distinct mid-bit sample.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
      return (div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : div;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_tick.sv
// Bit-rate counter: counts 0..div-1 while enabled, flags mid-bit and end-of-bit.
module baud_tick_gen
   import uart_rx_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick_c,
   output logic             half_tick_c
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;
   logic [DIV_W-1:0] last_c;

   assign last_c      = div - DIV_W'(1);
   assign bit_tick_c  = (count_q == last_c);
   assign half_tick_c = (count_q == (last_c >> 1));

   // Clear overrides enable so the FSM can hold the counter at zero while idle.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == last_c) ? '0 : count_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: input synchroniser, frame FSM, shift register, output handshake and sticky errors.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rx_d_q, rx_d_d;
   rx_state_e              state_q, state_d;
   logic [DIV_W-1:0]       dl_q, dl_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   busy_q, busy_d;

   logic rx_s;
   logic tick_en_c;
   logic tick_clr_c;
   logic half_tick;
   logic bit_tick_unused;

   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign tick_en_c  = (state_q != IDLE);
   assign tick_clr_c = (state_q == IDLE);

   baud_tick_gen u_tick (
      .clk         (clk),
      .rst         (rst),
      .en          (tick_en_c),
      .clr         (tick_clr_c),
      .div         (dl_q),
      .bit_tick_c  (bit_tick_unused),
      .half_tick_c (half_tick)
   );

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
      rx_d_d      = rx_s;
      state_d     = state_q;
      dl_d        = dl_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      // Clear first so a same-cycle set below wins.
      if (err_clr) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (rx_d_q && !rx_s) begin
               state_d = START;
               dl_d    = clamp_div(baud_div);
            end
         end
         START: begin
            if (half_tick) begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end
         end
         DATA: begin
            if (half_tick) begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (half_tick) begin
               state_d = IDLE;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
               end else if (!rx_valid_q || rx_ready) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '1;
         rx_d_q      <= 1'b1;
         state_q     <= IDLE;
         dl_q        <= MIN_BAUD_DIV;
         idx_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         rx_d_q      <= rx_d_d;
         state_q     <= state_d;
         dl_q        <= dl_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frame driver, byte scoreboard and directed/random frames.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [31:0] baud_div;
   logic        rx_ready;
   logic        err_clr;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        overrun;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   bit          abort  = 1'b0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .baud_div  (baud_div),
      .rx_ready  (rx_ready),
      .err_clr   (err_clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start, LSB-first data and stop bit, each held d cycles; returns early on abort.
   task automatic send_frame(input logic [7:0] data, input logic stop, input int d);
      logic [9:0] frame;
      frame = {stop, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         for (int c = 0; c < d; c++) begin
            @(negedge clk);
            if (abort) return;
         end
      end
      rx = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rx_data"},   32'(rx_data),   32'h0);
      chk({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
      chk({tag, "_overrun"},   32'(overrun),   32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
   endtask

   // Monitor: pops the scoreboard on every accepted byte and checks data is held while stalled.
   initial begin : monitor
      logic       hold;
      logic [7:0] held;
      hold = 1'b0;
      held = 8'h0;
      forever begin
         @(negedge clk);
         #1;
         if (hold) chk("data_stable", 32'(rx_data), 32'(held));
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
               chk("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
         end
         hold = rx_valid && !rx_ready && !rst;
         held = rx_data;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int         n;
      int         busy_cnt;
      bit         seen;
      bit         flag_seen;
      logic [7:0] data;
      logic       stop;
      int         d;

      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      baud_div = 32'd16;
      wait_cycles(3);
      chk_all_zero("reset");
      rst = 1'b0;
      wait_cycles(4);

      // 0xA5 at D=16: measure latency from START entry to rx_valid
      n = 0;
      fork
         send_frame(8'hA5, 1'b1, 16);
         begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               seen = busy;
            end
            chk("a5_busy_rise", 32'(seen), 32'h1);
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
               @(negedge clk);
               n++;
               seen = rx_valid;
            end
            chk("a5_valid_rise", 32'(seen), 32'h1);
            chk("a5_latency", 32'(n), 32'd152);
            chk("a5_busy_fall", 32'(busy), 32'h0);
            chk("a5_data", 32'(rx_data), 32'hA5);
            chk("a5_flags", 32'({frame_err, overrun}), 32'h0);
         end
      join
      exp_q.push_back(8'hA5);
      rx_ready = 1'b1;
      @(negedge clk);
      chk("a5_valid_drop", 32'(rx_valid), 32'h0);

      // False start: 3 low cycles
      wait_cycles(4);
      busy_cnt  = 0;
      flag_seen = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 2) rx = 1'b1;
         if (busy) busy_cnt++;
         if (rx_valid || frame_err || overrun) flag_seen = 1'b1;
      end
      chk("false_busy_cycles", 32'(busy_cnt), 32'd8);
      chk("false_no_output", 32'(flag_seen), 32'h0);

      // Framing error with 0x3C, then clear
      wait_cycles(4);
      send_frame(8'h3C, 1'b0, 16);
      wait_cycles(6);
      chk("fe_flag", 32'(frame_err), 32'h1);
      chk("fe_valid", 32'(rx_valid), 32'h0);
      chk("fe_overrun", 32'(overrun), 32'h0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("fe_cleared", 32'(frame_err), 32'h0);

      // Overrun: back-to-back 0x11, 0x22 at D=10 with consumer stalled
      baud_div = 32'd10;
      rx_ready = 1'b0;
      wait_cycles(4);
      send_frame(8'h11, 1'b1, 10);
      send_frame(8'h22, 1'b1, 10);
      wait_cycles(6);
      chk("ov_data", 32'(rx_data), 32'h11);
      chk("ov_flag", 32'(overrun), 32'h1);
      chk("ov_valid", 32'(rx_valid), 32'h1);
      chk("ov_frame_err", 32'(frame_err), 32'h0);
      exp_q.push_back(8'h11);
      rx_ready = 1'b1;
      @(negedge clk);
      chk("ov_valid_drop", 32'(rx_valid), 32'h0);

      // Reset in the middle of 0x55
      baud_div = 32'd16;
      wait_cycles(4);
      fork
         send_frame(8'h55, 1'b1, 16);
         begin
            wait_cycles(60);
            chk("rst_mid_busy", 32'(busy), 32'h1);
            rst   = 1'b1;
            abort = 1'b1;
            rx    = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_all_zero("rst_mid");
         end
      join
      abort = 1'b0;
      rx    = 1'b1;
      wait_cycles(4);
      exp_q.push_back(8'h66);
      send_frame(8'h66, 1'b1, 16);
      wait_cycles(6);

      // baud_div=0 clamps to 2
      baud_div = 32'd0;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 2);
      wait_cycles(6);
      chk("d0_frame_err", 32'(frame_err), 32'h0);

      // Divisor change mid-frame is ignored
      baud_div = 32'd16;
      data = 8'($urandom);
      exp_q.push_back(data);
      fork
         send_frame(data, 1'b1, 16);
         begin
            wait_cycles(40);
            baud_div = 32'd8;
         end
      join
      wait_cycles(6);
      chk("div_change_frame_err", 32'(frame_err), 32'h0);

      // Random frames, consumer always ready
      for (int f = 0; f < 12; f++) begin
         data = 8'($urandom);
         d    = int'($urandom_range(2, 20));
         stop = ($urandom_range(0, 3) != 0);
         baud_div = (d == 2 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1)) : 32'(d);
         if (stop) exp_q.push_back(data);
         wait_cycles(int'($urandom_range(1, 5)));
         send_frame(data, stop, d);
         wait_cycles(6);
         chk("rnd_frame_err", 32'(frame_err), 32'(!stop));
         chk("rnd_overrun", 32'(overrun), 32'h0);
         if (!stop) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
         end
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
